// File: rtl/serial_out_tx_if.sv
// Parallel-side and serial-side signals of the keypad serial transmitter.
// The producer (keypad encoder) uses the master view and the transmitter uses the slave view.
interface serial_out_tx_if #(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4
) ();
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] msg_in;
    logic              msg_valid;
    logic              msg_ready;
    logic              kb_init;
    logic              serial_o;
    logic              busy;
    logic              status_send;
    logic [LVL_W-1:0]  fifo_level;

    modport master (
        output msg_in, msg_valid,
        input  msg_ready, kb_init, serial_o, busy, status_send, fifo_level
    );

    modport slave (
        input  msg_in, msg_valid,
        output msg_ready, kb_init, serial_o, busy, status_send, fifo_level
    );
endinterface

// File: rtl/serial_out_tx.sv
// Keypad serial link transmitter: a small FIFO of key codes feeding a frame
// serializer. Each frame is one start cycle (kb_init), DATA_W data bits
// MSB-first on serial_o, then GAP_CYC forced idle cycles.
module serial_out_tx #(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYC    = 2
) (
    input  logic           clk,
    input  logic           reset,
    serial_out_tx_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]  count_reg;
    logic              kb_init_reg, serial_o_reg, status_reg;
    logic              kb_init_next, serial_o_next, status_next;
    logic              fifo_full, fifo_empty, push, pop;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    assign fifo_full  = (count_reg == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    // A full FIFO refuses writes even if the serializer pops on the same edge.
    assign push       = bus.msg_valid && !fifo_full;

    // FIFO storage: written on accepted push; head is read straight into the shift register on pop.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= bus.msg_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // Frame FSM next-state, shift/counter updates, and next values of the registered outputs.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        pop          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr_reg];
                    state_next = START;
                end
            end
            START: begin
                state_next   = DATA;
                bit_cnt_next = CNT_W'(DATA_W - 1);
            end
            DATA: begin
                shift_next = shift_reg << 1;
                if (bit_cnt_reg == '0) begin
                    state_next   = GAP;
                    gap_cnt_next = GAP_W'(GAP_CYC - 1);
                end else begin
                    bit_cnt_next = bit_cnt_reg - CNT_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt_reg == '0) begin
                    // Chain straight into the next frame so back-to-back frames
                    // are separated by exactly GAP_CYC idle cycles.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_mem[rd_ptr_reg];
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        // Outputs are computed from the next state so they line up with the state register.
        kb_init_next  = (state_next == START);
        serial_o_next = (state_next == DATA) && shift_next[DATA_W-1];
        status_next   = (state_reg == DATA) && (state_next == GAP);
    end

    // FSM state, datapath and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            gap_cnt_reg  <= '0;
            kb_init_reg  <= 1'b0;
            serial_o_reg <= 1'b0;
            status_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            kb_init_reg  <= kb_init_next;
            serial_o_reg <= serial_o_next;
            status_reg   <= status_next;
        end
    end

    assign bus.msg_ready   = !fifo_full;
    assign bus.kb_init     = kb_init_reg;
    assign bus.serial_o    = serial_o_reg;
    assign bus.status_send = status_reg;
    assign bus.busy        = (state_reg != IDLE) || !fifo_empty;
    assign bus.fifo_level  = count_reg;
endmodule

// File: tb/tb_serial_out_tx.sv
// Bench for serial_out_tx: a receiver model decodes frames from the serial side
// and compares them against a queue of codes accepted on the parallel side.
module tb_serial_out_tx;
    localparam int DATA_W     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int GAP_CYC    = 2;
    localparam int FRAME      = 1 + DATA_W + GAP_CYC;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    serial_out_tx_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    serial_out_tx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .GAP_CYC(GAP_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] exp_q [$];
    int init_q [$];
    int cycle_cnt = 0;
    int rx_phase  = 0;
    int rx_bit    = 0;
    int frames_rx = 0;
    int accepted  = 0;
    logic [DATA_W-1:0] rx_code = '0;
    logic [DATA_W-1:0] exp_code;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cycle_cnt);
        end
    endtask

    // Drive one cycle of parallel input; an accepted code goes into the scoreboard.
    task automatic drive(input logic v, input logic [DATA_W-1:0] d);
        @(negedge clk);
        bus.msg_valid = v;
        bus.msg_in    = d;
        #1;
        if (v && bus.msg_ready) begin
            exp_q.push_back(d);
            accepted++;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((bus.busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("drain_in_time", 32'(n < 300), 32'd1);
    endtask

    task automatic check_spacing();
        for (int i = 1; i < init_q.size(); i++)
            check_val("frame_spacing", 32'(init_q[i] - init_q[i-1]), 32'(FRAME));
    endtask

    always @(posedge clk) cycle_cnt++;

    // Receiver model: decodes frames and checks line discipline every cycle.
    always @(negedge clk) begin
        if (reset) begin
            rx_phase = 0;
            rx_bit   = 0;
        end else begin
            case (rx_phase)
                0: begin
                    check_val("status_idle", 32'(bus.status_send), 32'd0);
                    if (bus.kb_init) begin
                        check_val("start_line_low", 32'(bus.serial_o), 32'd0);
                        init_q.push_back(cycle_cnt);
                        rx_phase = 1;
                        rx_bit   = 0;
                        rx_code  = '0;
                    end else begin
                        check_val("idle_line_low", 32'(bus.serial_o), 32'd0);
                    end
                end
                1: begin
                    check_val("init_in_data", 32'(bus.kb_init), 32'd0);
                    check_val("status_in_data", 32'(bus.status_send), 32'd0);
                    rx_code = {rx_code[DATA_W-2:0], bus.serial_o};
                    rx_bit++;
                    if (rx_bit == DATA_W) begin
                        if (exp_q.size() == 0) begin
                            check_val("unexpected_frame", 32'(rx_code), 32'hFFFF_FFFF);
                        end else begin
                            exp_code = exp_q.pop_front();
                            check_val("rx_code", 32'(rx_code), 32'(exp_code));
                        end
                        frames_rx++;
                        $display("frame %0d received code=%h at cycle %0d", frames_rx, rx_code, cycle_cnt);
                        rx_phase = 2;
                    end
                end
                default: begin
                    check_val("status_pulse", 32'(bus.status_send), 32'd1);
                    check_val("gap_init_low", 32'(bus.kb_init), 32'd0);
                    check_val("gap_line_low", 32'(bus.serial_o), 32'd0);
                    rx_phase = 0;
                end
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rx0, acc0;
        bus.msg_valid = 1'b0;
        bus.msg_in    = '0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_kb_init", 32'(bus.kb_init), 32'd0);
        check_val("rst_serial", 32'(bus.serial_o), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_ready", 32'(bus.msg_ready), 32'd1);
        check_val("rst_level", 32'(bus.fifo_level), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single frame: latency, bit order, status pulse, busy release.
        init_q.delete();
        drive(1'b1, 4'b1011);
        drive(1'b0, '0);
        check_val("t1_level_after_push", 32'(bus.fifo_level), 32'd1);
        check_val("t1_no_init_yet", 32'(bus.kb_init), 32'd0);
        check_val("t1_busy", 32'(bus.busy), 32'd1);
        drive(1'b0, '0);
        check_val("t1_kb_init", 32'(bus.kb_init), 32'd1);
        check_val("t1_level_after_pop", 32'(bus.fifo_level), 32'd0);
        n = 0;
        while (!bus.status_send && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("t1_status_seen", 32'(bus.status_send), 32'd1);
        check_val("t1_busy_gap1", 32'(bus.busy), 32'd1);
        @(negedge clk); #1;
        check_val("t1_busy_gap2", 32'(bus.busy), 32'd1);
        @(negedge clk); #1;
        check_val("t1_busy_done", 32'(bus.busy), 32'd0);
        check_val("t1_frames", 32'(frames_rx), 32'd1);

        // Burst of codes, fill to full, then hold an invalid push while full.
        init_q.delete();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, DATA_W'(i));
            check_val("t2_ready_not_full", 32'(bus.msg_ready), 32'd1);
        end
        drive(1'b1, 4'h5);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'hF);
            check_val("t3_level_full", 32'(bus.fifo_level), 32'(FIFO_DEPTH));
            check_val("t3_ready_low", 32'(bus.msg_ready), 32'd0);
        end
        drive(1'b0, '0);
        wait_drain();
        check_val("t2_frame_count", 32'(init_q.size()), 32'd5);
        check_spacing();

        // Push while a frame is shifting out.
        init_q.delete();
        drive(1'b1, 4'h9);
        drive(1'b0, '0);
        n = 0;
        while (rx_phase != 1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("t4_in_data", 32'(rx_phase), 32'd1);
        drive(1'b1, 4'h6);
        drive(1'b0, '0);
        wait_drain();
        check_val("t4_frame_count", 32'(init_q.size()), 32'd2);
        check_spacing();

        // Reset during the second data bit with two codes queued.
        drive(1'b1, 4'h7);
        drive(1'b1, 4'h8);
        drive(1'b1, 4'hC);
        drive(1'b0, '0);
        n = 0;
        while (!(rx_phase == 1 && rx_bit == 1) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("t5_level_before", 32'(bus.fifo_level), 32'd2);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("t5_kb_init", 32'(bus.kb_init), 32'd0);
        check_val("t5_serial", 32'(bus.serial_o), 32'd0);
        check_val("t5_status", 32'(bus.status_send), 32'd0);
        check_val("t5_busy", 32'(bus.busy), 32'd0);
        check_val("t5_ready", 32'(bus.msg_ready), 32'd1);
        check_val("t5_level", 32'(bus.fifo_level), 32'd0);
        exp_q.delete();
        init_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check_val("t5_no_init_after_reset", 32'(init_q.size()), 32'd0);

        // Random push stream against the receiver model.
        rx0  = frames_rx;
        acc0 = accepted;
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 3) != 0, DATA_W'($urandom));
        drive(1'b0, '0);
        wait_drain();
        check_val("t6_all_received", 32'(frames_rx - rx0), 32'(accepted - acc0));
        check_val("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
